// File: rtl/multicycle_control.sv
// +----------------------------------------------------------------------------+
// | Module   : multicycle_control                                               |
// | Purpose  : Main sequencing FSM of the multicycle RV32I core. Decodes the    |
// |            opcode held in the IR and walks each instruction through         |
// |            fetch / decode / execute / memory / writeback. It drives the     |
// |            3-bit ALUop, the datapath mux selects and the register, PC and   |
// |            IR enables. It also handshakes with the shared memory port and   |
// |            applies a bounded wait timeout.                                  |
// | Ports    : CLK, RESET (async, active high)                                  |
// |            instruction[31:0], zero, mem_ready                 - inputs      |
// |            ALUop[2:0], ir_write, pc_write, pc_src, mem_req, mem_we,         |
// |            addr_sel, alu_src_a[1:0], alu_src_b[1:0], reg_write,             |
// |            wb_sel[1:0], retire, error, state[3:0]              - outputs    |
// |            illegal                          - output, ILLEGAL_TRAP_EN only  |
// | Macro    : ILLEGAL_TRAP_EN - undefined opcodes enter a sticky TRAP state    |
// |            instead of returning silently to FETCH.                          |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module multicycle_control #(
  parameter int MAX_WAIT = 200,
  parameter int WAIT_W   = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  ALUop,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        error,
`ifdef ILLEGAL_TRAP_EN
  output logic        illegal,
`endif
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_LUI      = 4'd4,
    ST_AUIPC    = 4'd5,
    ST_WB_ALU   = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_MEM_WR   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JAL      = 4'd12,
    ST_JALR     = 4'd13,
    ST_ERROR    = 4'd14,
    ST_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i      = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;

  // Timeout fires on the MAX_WAIT-th consecutive cycle without mem_ready.
  localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] c_wait_max  = WAIT_W'(MAX_WAIT);

  state_t            r_state;
  state_t            w_state_next;
  logic [WAIT_W-1:0] r_wait;
  logic              w_timeout;

  // Only the opcode field steers sequencing.
  logic w_unused_instr;
  assign w_unused_instr = &{1'b0, instruction[31:7]};

  assign state     = r_state;
  assign w_timeout = (r_wait == c_wait_last) && !mem_ready;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Wait counter restarts on every state change so each access gets its own
  // full MAX_WAIT budget.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wait <= '0;
    end else if (w_state_next != r_state) begin
      r_wait <= '0;
    end else if (mem_req && !mem_ready && (r_wait != c_wait_max)) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ALUop        = 3'b010;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    retire       = 1'b0;
    error        = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal      = 1'b0;
`endif
    // Outputs are forced to their idle values while RESET is high so that an
    // in-flight memory request is withdrawn without waiting for a clock.
    if (!RESET) begin
      case (r_state)
        ST_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_write     = 1'b1;
            w_state_next = ST_DECODE;
          end else if (w_timeout) begin
            w_state_next = ST_ERROR;
          end
        end
        ST_DECODE: begin
          // ALUout captures oldPC + imm for branch/jump targets.
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
          case (instruction[6:0])
            c_op_r:                 w_state_next = ST_EXEC_R;
            c_op_i:                 w_state_next = ST_EXEC_I;
            c_op_load, c_op_store:  w_state_next = ST_MEM_ADDR;
            c_op_branch:            w_state_next = ST_BRANCH;
            c_op_jal:               w_state_next = ST_JAL;
            c_op_jalr:              w_state_next = ST_JALR;
            c_op_lui:               w_state_next = ST_LUI;
            c_op_auipc:             w_state_next = ST_AUIPC;
`ifdef ILLEGAL_TRAP_EN
            default:                w_state_next = ST_TRAP;
`else
            default:                w_state_next = ST_FETCH;
`endif
          endcase
        end
        ST_EXEC_R: begin
          alu_src_a = 2'b01; alu_src_b = 2'b00; ALUop = 3'b000;
          w_state_next = ST_WB_ALU;
        end
        ST_EXEC_I: begin
          alu_src_a = 2'b01; alu_src_b = 2'b10; ALUop = 3'b001;
          w_state_next = ST_WB_ALU;
        end
        ST_LUI: begin
          alu_src_a = 2'b11; alu_src_b = 2'b10; ALUop = 3'b101;
          w_state_next = ST_WB_ALU;
        end
        ST_AUIPC: begin
          alu_src_a = 2'b10; alu_src_b = 2'b10; ALUop = 3'b110;
          w_state_next = ST_WB_ALU;
        end
        ST_WB_ALU: begin
          reg_write = 1'b1; wb_sel = 2'b00; retire = 1'b1;
          w_state_next = ST_FETCH;
        end
        ST_MEM_ADDR: begin
          // Opcode bit 5 separates store (0100011) from load (0000011).
          alu_src_a = 2'b01; alu_src_b = 2'b10;
          ALUop = instruction[5] ? 3'b011 : 3'b010;
          w_state_next = instruction[5] ? ST_MEM_WR : ST_MEM_RD;
        end
        ST_MEM_RD: begin
          mem_req = 1'b1; addr_sel = 1'b1;
          if (mem_ready)      w_state_next = ST_WB_MEM;
          else if (w_timeout) w_state_next = ST_ERROR;
        end
        ST_WB_MEM: begin
          reg_write = 1'b1; wb_sel = 2'b01; retire = 1'b1;
          w_state_next = ST_FETCH;
        end
        ST_MEM_WR: begin
          mem_req = 1'b1; mem_we = 1'b1; addr_sel = 1'b1;
          if (mem_ready) begin
            retire       = 1'b1;
            w_state_next = ST_FETCH;
          end else if (w_timeout) begin
            w_state_next = ST_ERROR;
          end
        end
        ST_BRANCH: begin
          alu_src_a = 2'b01; alu_src_b = 2'b00; ALUop = 3'b100;
          pc_write = zero; pc_src = 1'b1; retire = 1'b1;
          w_state_next = ST_FETCH;
        end
        ST_JAL: begin
          ALUop = 3'b111; pc_write = 1'b1; pc_src = 1'b1;
          reg_write = 1'b1; wb_sel = 2'b10; retire = 1'b1;
          w_state_next = ST_FETCH;
        end
        ST_JALR: begin
          alu_src_a = 2'b01; alu_src_b = 2'b10; ALUop = 3'b001;
          pc_write = 1'b1; pc_src = 1'b0;
          reg_write = 1'b1; wb_sel = 2'b10; retire = 1'b1;
          w_state_next = ST_FETCH;
        end
        ST_ERROR: begin
          error = 1'b1;
        end
        ST_TRAP: begin
          error = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          illegal = 1'b1;
`endif
        end
        default: w_state_next = ST_FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_multicycle_control                                            |
// | Purpose  : Self-checking bench for multicycle_control. Each instruction is  |
// |            expanded into its list of phases, and every cycle's outputs are  |
// |            compared with the values the phase rules predict.                |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] instruction;
  logic        zero;
  logic        mem_ready;
  logic [2:0]  ALUop;
  logic        ir_write, pc_write, pc_src, mem_req, mem_we, addr_sel;
  logic [1:0]  alu_src_a, alu_src_b, wb_sel;
  logic        reg_write, retire, error;
  logic [3:0]  state;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  always #5 CLK = ~CLK;

  multicycle_control dut (
    .CLK(CLK), .RESET(RESET), .instruction(instruction), .zero(zero),
    .mem_ready(mem_ready), .ALUop(ALUop), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire), .error(error),
`ifdef ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .state(state)
  );

  typedef struct packed {
    logic [2:0] aluop;
    logic       ir_write, pc_write, pc_src, mem_req, mem_we, addr_sel;
    logic [1:0] src_a, src_b;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       retire, error, illegal;
  } outs_t;

  typedef enum {
    P_RESET, P_FETCH, P_DECODE, P_EXR, P_EXI, P_LUI, P_AUIPC, P_WBALU,
    P_MADDR_LD, P_MADDR_ST, P_MEMRD, P_WBMEM, P_MEMWR, P_BRANCH, P_JAL,
    P_JALR, P_ERROR, P_TRAP
  } phase_t;

  int vectors = 0;
  int miscompares = 0;
  int dut_retires = 0;
  int exp_retires = 0;

  always @(posedge CLK) if (retire === 1'b1) dut_retires++;

  // Expected outputs of one cycle, from the per-phase rules.
  function automatic outs_t model(phase_t ph, logic rdy, logic z);
    outs_t o;
    o = '0;
    o.aluop = 3'b010;
    case (ph)
      P_FETCH:    begin o.mem_req = 1; o.src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      P_DECODE:   begin o.src_a = 2'b10; o.src_b = 2'b10; end
      P_EXR:      begin o.src_a = 2'b01; o.src_b = 2'b00; o.aluop = 3'b000; end
      P_EXI:      begin o.src_a = 2'b01; o.src_b = 2'b10; o.aluop = 3'b001; end
      P_LUI:      begin o.src_a = 2'b11; o.src_b = 2'b10; o.aluop = 3'b101; end
      P_AUIPC:    begin o.src_a = 2'b10; o.src_b = 2'b10; o.aluop = 3'b110; end
      P_WBALU:    begin o.reg_write = 1; o.wb_sel = 2'b00; o.retire = 1; end
      P_MADDR_LD: begin o.src_a = 2'b01; o.src_b = 2'b10; o.aluop = 3'b010; end
      P_MADDR_ST: begin o.src_a = 2'b01; o.src_b = 2'b10; o.aluop = 3'b011; end
      P_MEMRD:    begin o.mem_req = 1; o.addr_sel = 1; end
      P_WBMEM:    begin o.reg_write = 1; o.wb_sel = 2'b01; o.retire = 1; end
      P_MEMWR:    begin o.mem_req = 1; o.mem_we = 1; o.addr_sel = 1; o.retire = rdy; end
      P_BRANCH:   begin o.src_a = 2'b01; o.aluop = 3'b100; o.pc_write = z; o.pc_src = 1; o.retire = 1; end
      P_JAL:      begin o.aluop = 3'b111; o.pc_write = 1; o.pc_src = 1; o.reg_write = 1;
                        o.wb_sel = 2'b10; o.retire = 1; end
      P_JALR:     begin o.src_a = 2'b01; o.src_b = 2'b10; o.aluop = 3'b001; o.pc_write = 1;
                        o.reg_write = 1; o.wb_sel = 2'b10; o.retire = 1; end
      P_ERROR:    o.error = 1;
      P_TRAP:     begin o.error = 1; o.illegal = 1; end
      default:    ;
    endcase
    return o;
  endfunction

  function automatic outs_t observed();
    outs_t o;
    o.aluop = ALUop; o.ir_write = ir_write; o.pc_write = pc_write; o.pc_src = pc_src;
    o.mem_req = mem_req; o.mem_we = mem_we; o.addr_sel = addr_sel;
    o.src_a = alu_src_a; o.src_b = alu_src_b; o.reg_write = reg_write;
    o.wb_sel = wb_sel; o.retire = retire; o.error = error;
`ifdef ILLEGAL_TRAP_EN
    o.illegal = illegal;
`else
    o.illegal = 1'b0;
`endif
    return o;
  endfunction

  task automatic compare(input phase_t ph, input logic rdy, input logic z);
    outs_t exp, got;
    exp = model(ph, rdy, z);
    got = observed();
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", ph.name(), got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check mid-cycle, advance past the edge.
  task automatic step(input phase_t ph, input logic rdy, input logic z);
    mem_ready = rdy;
    zero      = z;
    @(negedge CLK);
    compare(ph, rdy, z);
    @(posedge CLK);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic fetch(input int fw, input logic [31:0] instr);
    for (int i = 0; i < fw; i++) step(P_FETCH, 1'b0, rb());
    step(P_FETCH, 1'b1, rb());
    instruction = instr;
    step(P_DECODE, rb(), rb());
  endtask

  // Full instruction with fw fetch wait cycles and dw data wait cycles.
  task automatic run_instr(input logic [31:0] instr, input int fw, input int dw, input logic z);
    fetch(fw, instr);
    case (instr[6:0])
      7'h33: begin step(P_EXR, rb(), rb());   step(P_WBALU, rb(), rb()); exp_retires++; end
      7'h13: begin step(P_EXI, rb(), rb());   step(P_WBALU, rb(), rb()); exp_retires++; end
      7'h37: begin step(P_LUI, rb(), rb());   step(P_WBALU, rb(), rb()); exp_retires++; end
      7'h17: begin step(P_AUIPC, rb(), rb()); step(P_WBALU, rb(), rb()); exp_retires++; end
      7'h03: begin
        step(P_MADDR_LD, rb(), rb());
        for (int i = 0; i < dw; i++) step(P_MEMRD, 1'b0, rb());
        step(P_MEMRD, 1'b1, rb());
        step(P_WBMEM, rb(), rb());
        exp_retires++;
      end
      7'h23: begin
        step(P_MADDR_ST, rb(), rb());
        for (int i = 0; i < dw; i++) step(P_MEMWR, 1'b0, rb());
        step(P_MEMWR, 1'b1, rb());
        exp_retires++;
      end
      7'h63: begin step(P_BRANCH, rb(), z); exp_retires++; end
      7'h6F: begin step(P_JAL, rb(), rb());  exp_retires++; end
      7'h67: begin step(P_JALR, rb(), rb()); exp_retires++; end
      default: ; // undefined opcode: nothing after DECODE
    endcase
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    compare(P_RESET, mem_ready, zero);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  logic [6:0] ops [$];

  initial begin
    RESET = 1'b1; mem_ready = 1'b0; zero = 1'b0; instruction = 32'h0;
    #1;
    compare(P_RESET, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    mem_ready = 1'b1;
    compare(P_RESET, 1'b1, 1'b0);
    RESET = 1'b0;

    // add x3,x1,x2 with zero-wait memory
    run_instr(32'h002081B3, 0, 0, 1'b0);
    // lw with 3-cycle data wait: MEM_RD held four cycles
    run_instr(32'h0000A183, 0, 3, 1'b0);
    // beq x1,x1 taken then not taken
    run_instr(32'h00108063, 0, 0, 1'b1);
    run_instr(32'h00108063, 0, 0, 1'b0);
    // store, jal, jalr, lui, auipc, addi
    run_instr(32'h0020A023, 1, 0, 1'b0);
    run_instr(32'h0000006F, 0, 0, 1'b0);
    run_instr(32'h00008067, 0, 0, 1'b0);
    run_instr(32'h123450B7, 0, 0, 1'b0);
    run_instr(32'h00001097, 0, 0, 1'b0);
    run_instr(32'h00108093, 2, 0, 1'b0);

    // Memory ready on the last allowed cycle is still accepted.
    for (int i = 0; i < 199; i++) step(P_FETCH, 1'b0, rb());
    step(P_FETCH, 1'b1, rb());
    instruction = 32'h002081B3;
    step(P_DECODE, rb(), rb());
    step(P_EXR, rb(), rb());
    step(P_WBALU, rb(), rb());
    exp_retires++;

    // Fetch timeout: 200 cycles without mem_ready, then sticky ERROR.
    for (int i = 0; i < 200; i++) step(P_FETCH, 1'b0, rb());
    for (int i = 0; i < 4; i++) step(P_ERROR, rb(), rb());
    do_reset();

    // Undefined opcode
    fetch(0, 32'h0000007F);
`ifdef ILLEGAL_TRAP_EN
    step(P_TRAP, rb(), rb());
    step(P_TRAP, rb(), rb());
    do_reset();
`endif
    run_instr(32'h002081B3, 0, 0, 1'b0);

    // Reset asserted in the middle of a store access
    fetch(0, 32'h0020A023);
    step(P_MADDR_ST, rb(), rb());
    mem_ready = 1'b0;
    @(negedge CLK);
    compare(P_MEMWR, 1'b0, zero);
    #2;
    RESET = 1'b1;
    #1;
    compare(P_RESET, 1'b0, zero);
    @(posedge CLK);
    #1;
    compare(P_RESET, 1'b0, zero);
    RESET = 1'b0;
    run_instr(32'h0000A183, 0, 1, 1'b0);

    // Randomized instruction stream
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
`ifndef ILLEGAL_TRAP_EN
    ops.push_back(7'h7F);
    ops.push_back(7'h0F);
    ops.push_back(7'h00);
`endif
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, ops.size() - 1)];
      run_instr({25'($urandom), op}, $urandom_range(0, 2), $urandom_range(0, 3), rb());
    end

    @(negedge CLK);
    vectors++;
    assert (dut_retires === exp_retires) else begin
      miscompares++;
      $error("FAIL retire_count observed=%0d expected=%0d", dut_retires, exp_retires);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main sequencing FSM for the multicycle RV32I core.
- Decodes the opcode from the instruction register and walks each instruction through fetch/decode/execute/memory/writeback.
- Drives the 3-bit ALUop consumed by the ALU control decoder, plus datapath mux selects and register/PC/IR enables.
- Handshakes with the shared instruction/data memory port, with a bounded wait timeout.

Parameters:
- MAX_WAIT, 200: cycles allowed for mem_ready after mem_req before entering ERROR.
- WAIT_W, 8: width of the wait counter; must hold MAX_WAIT.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- instruction  in  32  IR contents; stable from the cycle after ir_write.
- zero  in  1  ALU zero flag; in BRANCH, 1 means branch taken.
- mem_ready  in  1  memory completes the current access this cycle.
- ALUop  out  3  000 R, 001 I-arith/JALR, 010 add (load/addr/PC+4), 011 store, 100 branch, 101 lui, 110 auipc, 111 jal.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  load PC from the PC-source mux.
- pc_src  out  1  0 = ALU result, 1 = ALUout register.
- mem_req  out  1  memory access request.
- mem_we  out  1  write when mem_req=1.
- addr_sel  out  1  0 = PC, 1 = ALUout.
- alu_src_a  out  2  00 PC, 01 rs1, 10 oldPC, 11 const 0.
- alu_src_b  out  2  00 rs2, 01 const 4, 10 imm.
- reg_write  out  1  register file write enable.
- wb_sel  out  2  00 ALUout, 01 memory data, 10 oldPC+4.
- retire  out  1  one-cycle pulse when an instruction completes.
- error  out  1  sticky memory timeout flag.
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset (async, RESET=1): state=FETCH, wait counter=0, error=0, all enables 0, selects 0, ALUop=010. Outputs are Moore and depend on state only, except pc_write in BRANCH (zero-gated) and enables gated by mem_ready.
- FETCH: mem_req=1, addr_sel=0, src_a=PC, src_b=4, ALUop=010. On mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE. Otherwise stay and increment the wait counter.
- DECODE: src_a=oldPC, src_b=imm, ALUop=010 (ALUout <= branch/jump target). Dispatch on instruction[6:0]:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011, 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - other -> FETCH, no architectural effect, retire=0.
- EXEC_R: src_a=rs1, src_b=rs2, ALUop=000 -> WB_ALU.
- EXEC_I: src_a=rs1, src_b=imm, ALUop=001 -> WB_ALU.
- LUI: src_a=0, src_b=imm, ALUop=101 -> WB_ALU.
- AUIPC: src_a=oldPC, src_b=imm, ALUop=110 -> WB_ALU.
- WB_ALU: reg_write=1, wb_sel=00, retire=1 -> FETCH.
- MEM_ADDR: src_a=rs1, src_b=imm, ALUop=010 for load, 011 for store (opcode bit 5). Next: MEM_RD for load, MEM_WR for store.
- MEM_RD: mem_req=1, addr_sel=1, mem_we=0. On mem_ready -> WB_MEM.
- WB_MEM: reg_write=1, wb_sel=01, retire=1 -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, addr_sel=1. On mem_ready: retire=1 -> FETCH.
- BRANCH: src_a=rs1, src_b=rs2, ALUop=100. pc_write=zero, pc_src=1, retire=1 -> FETCH.
- JAL: ALUop=111, pc_write=1, pc_src=1, reg_write=1, wb_sel=10, retire=1 -> FETCH.
- JALR: src_a=rs1, src_b=imm, ALUop=001, pc_write=1, pc_src=0, reg_write=1, wb_sel=10, retire=1 -> FETCH.
- Latency: R/I/LUI/AUIPC = 4 cycles; load = 5; store = 4; branch/jal/jalr = 3; each with zero-wait memory.
- Wait counter: cleared on every state change. Counts only while mem_req=1 and mem_ready=0; saturates at MAX_WAIT. If it reaches MAX_WAIT with mem_ready still 0, go to ERROR.
- ERROR: all enables 0, mem_req=0, error=1. Held until RESET.
- mem_ready with mem_req=0: ignored.
- RESET mid-access: mem_req drops immediately (async); no partial writes are issued by this block.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in DECODE goes to TRAP. TRAP asserts error=1 and illegal=1 (extra 1-bit output) and is held until RESET.
- Undefined: undefined opcodes return silently to FETCH, and the illegal port is absent.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready always 1 -> states FETCH,DECODE,EXEC_R,WB_ALU. ALUop=000 in EXEC_R; reg_write=1 and retire=1 in cycle 4 only.
- lw (0x0000A183) with mem_ready delayed 3 cycles on data read -> MEM_RD held 4 cycles, then WB_MEM with wb_sel=01. Total 8 cycles to retire.
- beq x1,x1 with zero=1 -> pc_write=1, pc_src=1 in BRANCH. Repeat with zero=0 -> pc_write=0. Both retire in 3 cycles.
- mem_ready held 0 in FETCH -> after MAX_WAIT=200 cycles state=ERROR, error=1, mem_req=0. Persists until RESET.
- RESET asserted during MEM_WR, mid-cycle -> outputs clear asynchronously. After release, first state is FETCH.
- Opcode 0x0000007F -> returns to FETCH with no reg_write. With ILLEGAL_TRAP_EN, enters TRAP with illegal=1.
